data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 256, meaning the number of 32-bit memory words (power of two, at least 4).
REQ-002 SHALL provide parameter ERR_CNT_W, default 8, meaning the width of the saturating error counter.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL provide port req_valid, input, 1 bit: the core presents a load/store request.
REQ-006 SHALL provide port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL provide port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL provide port req_funct3, input, 3 bits: RV32I load/store size and sign field.
REQ-009 SHALL provide port req_addr, input, 32 bits: byte address.
REQ-010 SHALL provide port req_wdata, input, 32 bits: store data, LSB-aligned.
REQ-011 SHALL provide port rsp_valid, output, 1 bit: a response is presented.
REQ-012 SHALL provide port rsp_ready, input, 1 bit: the core accepts the response.
REQ-013 SHALL provide port rsp_rdata, output, 32 bits: load result, already extended.
REQ-014 SHALL provide port rsp_err, output, 1 bit: the request was rejected with no memory side effect.
REQ-015 SHALL provide port err_count, output, ERR_CNT_W bits: the saturating count of error responses.

Function
REQ-016 SHALL implement states IDLE, ACCESS and RESP; IDLE->ACCESS on req_valid&&req_ready; ACCESS->RESP unconditionally; RESP->IDLE on rsp_ready, otherwise hold RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; all request fields are captured into registers on acceptance.
REQ-018 SHALL assert rsp_valid exactly 2 cycles after the accept edge, and hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready.
REQ-019 SHALL accept a new request no earlier than the cycle after the RESP->IDLE transition; there is no back-to-back overlap.
REQ-020 SHALL use the word index addr[log2(DEPTH_WORDS)+1:2] and byte lane addr[1:0], little-endian.
REQ-021 SHALL decode loads as funct3 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend).
REQ-022 SHALL decode stores as funct3 000 SB, 001 SH, 010 SW; SB/SH write only the addressed lanes, and other bytes of the word are unchanged.
REQ-023 SHALL flag an error for any other funct3 (loads: 011, 110, 111; stores: 011-111).
REQ-024 SHALL flag an error for misalignment: halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-025 SHALL flag an error for out-of-range access: addr[31:2] >= DEPTH_WORDS.
REQ-026 SHALL commit the store write in the ACCESS cycle only when no error is flagged; an errored store SHALL leave memory unchanged.
REQ-027 SHALL perform the load read synchronously in ACCESS, with extension applied into the rsp_rdata register at the ACCESS->RESP edge.
REQ-028 SHALL drive rsp_rdata=0 for store responses and for all error responses.
REQ-029 SHALL increment err_count by 1 on each ACCESS->RESP edge with an error, saturating at all-ones without wrapping.
REQ-030 SHALL make a load from an address stored earlier return the stored value, with no forwarding hazard (sequential requests only).

Reset
REQ-031 SHALL, with rst=1 at a clock edge, set state=IDLE, req_ready=1 (from the next cycle), rsp_valid=0, rsp_rdata=0, rsp_err=0 and err_count=0.
REQ-032 SHALL leave memory contents unchanged by reset, and uninitialised contents SHALL NOT be relied on.
REQ-033 SHALL suppress the store write when rst=1 in the ACCESS cycle, and drop any pending response without asserting rsp_valid.
REQ-034 SHALL give rst priority over every simultaneous event, including req_valid or rsp_ready in the same cycle.

Verification
REQ-035 SHALL cover: SW 0x8000_00F1 to addr 0x10, then LB at 0x10 -> rsp_rdata=0xFFFF_FFF1; LBU at 0x13 -> 0x0000_0080; LH at 0x12 -> 0xFFFF_8000.
REQ-036 SHALL cover: SW 0x1122_3344 at 0x20, then SB 0xAA at 0x21, then LW 0x20 -> 0x1122_AA44; SH 0xBEEF at 0x22, then LW -> 0xBEEF_AA44.
REQ-037 SHALL cover: LW at 0x22 -> rsp_err=1, rsp_rdata=0; SH at 0x23 -> rsp_err=1, and a following LW at 0x20 shows memory unchanged; err_count=2.
REQ-038 SHALL cover: LW at byte address 4*DEPTH_WORDS -> rsp_err=1; store with funct3=011 -> rsp_err=1, memory unchanged.
REQ-039 SHALL cover: accept at cycle N -> rsp_valid at N+2; hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout; rsp_ready=1 -> req_ready=1 the next cycle.
REQ-040 SHALL cover: rst during the ACCESS cycle of SW 0xDEAD_BEEF to a word holding 0 -> no rsp_valid, all outputs at reset values, and a later LW returns 0; force 2^ERR_CNT_W+3 errors -> err_count saturates at all-ones.

Source files
------------

// File: rtl/data_mem_resp.sv
// Single-port word memory behind a valid/ready load/store port for an RV32I core.
// One request in flight: IDLE accepts, ACCESS reads/writes the array, RESP holds the answer.
module data_mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic                   we_q;
  logic [2:0]             f3_q;
  logic [31:0]            addr_q, wdata_q;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q;
  logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]            mem [DEPTH_WORDS];

  logic [AW-1:0]          idx;
  logic [1:0]             lane;
  logic                   f3_bad, misal, oor, err;
  logic [31:0]            rd_word, rd_sh, ld_ext;
  logic [3:0]             be;
  logic [31:0]            wd_rep;
  logic                   wr_en;

  assign idx  = addr_q[AW+1:2];
  assign lane = addr_q[1:0];

  // Error classification of the captured request
  always_comb begin
    f3_bad = 1'b0;
    if (we_q) f3_bad = f3_q[2] | (f3_q[1:0] == 2'b11);
    else      f3_bad = (f3_q == 3'b011) | (f3_q[2:1] == 2'b11);
    misal = ((f3_q[1:0] == 2'b01) && lane[0]) ||
            ((f3_q[1:0] == 2'b10) && (lane != 2'b00));
    oor   = (addr_q[31:2] >= DEPTH_LIM);
    err   = f3_bad | misal | oor;
  end

  // Load path: select the addressed lanes and extend
  always_comb begin
    rd_word = mem[idx];
    rd_sh   = rd_word >> {lane, 3'b000};
    ld_ext  = '0;
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b010:  ld_ext = rd_word;
      3'b100:  ld_ext = {24'h0, rd_sh[7:0]};
      3'b101:  ld_ext = {16'h0, rd_sh[15:0]};
      default: ld_ext = '0;
    endcase
    rdata_d = (we_q || err) ? 32'h0 : ld_ext;
  end

  // Store path: replicate data across lanes, byte enables pick the target
  always_comb begin
    be     = 4'b0000;
    wd_rep = wdata_q;
    case (f3_q[1:0])
      2'b00:   begin be = 4'b0001 << lane; wd_rep = {4{wdata_q[7:0]}};  end
      2'b01:   begin be = 4'b0011 << lane; wd_rep = {2{wdata_q[15:0]}}; end
      2'b10:   begin be = 4'b1111;         wd_rep = wdata_q;            end
      default: begin be = 4'b0000;         wd_rep = wdata_q;            end
    endcase
    wr_en = !rst && (state_q == S_ACCESS) && we_q && !err;
  end

  // Memory is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd_rep[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ACCESS && err && cnt_q != {ERR_CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_ACCESS) begin
        rdata_q <= rdata_d;
        err_q   <= err;
      end
    end
  end

  // Request capture registers need no reset: they are only read after an accept
  always_ff @(posedge clk) begin
    if (!rst && req_valid && req_ready) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed + randomized bench for data_mem_resp against a byte-array reference model.
module tb_data_mem_resp;
  localparam int DEPTH = 16;
  localparam int EW    = 4;

  logic          clk, rst;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [EW-1:0] err_count;

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] mm [DEPTH*4];
  int         exp_errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat_cnt();
    return (exp_errs > (2**EW - 1)) ? 32'(2**EW - 1) : 32'(exp_errs);
  endfunction

  // Reference: byte-addressed memory, size from funct3, plain arithmetic extension
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic e, output logic [31:0] rd);
    int sz;
    logic [31:0] v;
    e = 1'b0; rd = 32'h0; sz = 0;
    if (we) begin
      if (f3 <= 3'd2) sz = 1 << f3;
    end else if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
      sz = 1 << f3[1:0];
    end
    if (sz == 0)                   e = 1'b1;
    else if ((a % sz) != 0)        e = 1'b1;
    else if ((a >> 2) >= DEPTH)    e = 1'b1;
    if (e) return;
    if (we) begin
      for (int i = 0; i < sz; i++) mm[a + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v = v | (32'(mm[a + i]) << (8 * i));
      if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int stall,
                        output logic [31:0] rd_o, output logic err_o);
    logic        e;
    logic [31:0] r;
    int          n;
    model(we, f3, a, wd, e, r);
    if (e) exp_errs++;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin tick; n++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    tick;
    // Scramble request lines after accept: the captured copy must be used
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    chk("rsp_valid_n1", 32'(rsp_valid), 32'd0);
    chk("req_ready_access", 32'(req_ready), 32'd0);
    tick;
    chk("rsp_valid_n2", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", rsp_rdata, r);
    chk("rsp_err", 32'(rsp_err), 32'(e));
    chk("err_count", 32'(err_count), sat_cnt());
    rd_o = rsp_rdata; err_o = rsp_err;
    for (int s = 0; s < stall; s++) begin
      tick;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, r);
      chk("hold_err", 32'(rsp_err), 32'(e));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("ready_after_rsp", 32'(req_ready), 32'd1);
    chk("valid_after_rsp", 32'(rsp_valid), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] ra;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) tick;
    chk_reset_outs("reset");
    rst = 1'b0;
    tick;
    chk_reset_outs("post_reset");

    // Fill memory so nothing depends on uninitialised contents
    for (int w = 0; w < DEPTH; w++) do_req(1'b1, 3'b010, 32'(w * 4), $urandom, 0, rd, er);

    // Sign/zero extension
    do_req(1'b1, 3'b010, 32'h10, 32'h8000_00F1, 0, rd, er);
    do_req(1'b0, 3'b000, 32'h10, 32'h0, 0, rd, er); chk("lb_0x10", rd, 32'hFFFF_FFF1);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, er); chk("lbu_0x13", rd, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er); chk("lh_0x12", rd, 32'hFFFF_8000);

    // Partial stores merge into the word
    do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, 0, rd, er);
    do_req(1'b1, 3'b000, 32'h21, 32'h5566_77AA, 0, rd, er);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er); chk("lw_after_sb", rd, 32'h1122_AA44);
    do_req(1'b1, 3'b001, 32'h22, 32'h1234_BEEF, 0, rd, er);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er); chk("lw_after_sh", rd, 32'hBEEF_AA44);

    // Misalignment
    do_req(1'b0, 3'b010, 32'h22, 32'h0, 0, rd, er);
    chk("lw_misal_err", 32'(er), 32'd1); chk("lw_misal_rdata", rd, 32'd0);
    do_req(1'b1, 3'b001, 32'h23, 32'h0000_FFFF, 0, rd, er); chk("sh_misal_err", 32'(er), 32'd1);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er); chk("lw_unchanged1", rd, 32'hBEEF_AA44);
    chk("err_count_two", 32'(err_count), 32'd2);

    // Out of range and illegal store funct3
    do_req(1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, 0, rd, er); chk("lw_oor_err", 32'(er), 32'd1);
    do_req(1'b1, 3'b011, 32'h20, 32'h0, 0, rd, er); chk("st_f3_011_err", 32'(er), 32'd1);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er); chk("lw_unchanged2", rd, 32'hBEEF_AA44);

    // Backpressure: response held for 5 cycles
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 5, rd, er);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ra = $urandom;
      else ra = 32'($urandom_range(0, DEPTH * 4 + 7));
      do_req(rwe, rf3, ra, $urandom, int'($urandom_range(0, 2)), rd, er);
    end

    // Reset during ACCESS of a store: write dropped, no response
    do_req(1'b1, 3'b010, 32'h30, 32'h0, 0, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h30; req_wdata = 32'hDEAD_BEEF;
    tick;
    chk("rst_acc_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1; rsp_ready = 1'b1;
    tick;
    chk_reset_outs("rst_access");
    req_valid = 1'b0; rsp_ready = 1'b0;
    rst = 1'b0;
    exp_errs = 0;
    tick;
    chk("rst_no_valid1", 32'(rsp_valid), 32'd0);
    tick;
    chk("rst_no_valid2", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 3'b010, 32'h30, 32'h0, 0, rd, er); chk("lw_after_rst", rd, 32'h0);

    // Saturation
    for (int k = 0; k < (2**EW) + 3; k++) do_req(1'b0, 3'b011, 32'h0, 32'h0, 0, rd, er);
    chk("err_count_sat", 32'(err_count), 32'(2**EW - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
